// File: rtl/partoserial_param.sv
// Parallel-to-serial converter for the PHY transmit path: one-entry holding register, IDLE fill, per-frame bit order.
// Optional even-parity bit per frame and parity_out port when PARTOSERIAL_PARITY_EN is defined.
module partoserial_param #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] IDLE = WIDTH'(8'hBC),
  parameter int              CNT_W = 8
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             lsb_first,
  output logic             data_out,
  output logic             frame_start,
  output logic             sending_idle,
  output logic [CNT_W-1:0] idle_cnt
`ifdef PARTOSERIAL_PARITY_EN
  ,
  output logic             parity_out
`endif
);

`ifdef PARTOSERIAL_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(FL + 1);

  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic [WIDTH-1:0] shreg;
  logic             order_lsb;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] word;
  logic             word_idle;
  logic             ser_bit;
`ifdef PARTOSERIAL_PARITY_EN
  logic             par_bit;
`endif

  assign load      = (bit_cnt == '0);
  assign ready_out = reset & (~hold_valid | load);
  assign accept    = valid_in & ready_out;

  // Word selection at a frame boundary: held word beats a same-cycle bypass.
  always_comb begin
    word      = IDLE;
    word_idle = 1'b1;
    if (hold_valid) begin
      word      = hold;
      word_idle = 1'b0;
    end else if (accept) begin
      word      = data_in;
      word_idle = 1'b0;
    end
  end

  // shreg advances one place per bit, so the next bit always sits next to the end.
  always_comb begin
    ser_bit = order_lsb ? shreg[1] : shreg[WIDTH-2];
`ifdef PARTOSERIAL_PARITY_EN
    if (bit_cnt == CW'(WIDTH)) ser_bit = par_bit;
`endif
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      bit_cnt      <= '0;
      hold         <= '0;
      hold_valid   <= 1'b0;
      shreg        <= IDLE;
      order_lsb    <= 1'b0;
      data_out     <= 1'b0;
      frame_start  <= 1'b0;
      sending_idle <= 1'b0;
      idle_cnt     <= '0;
`ifdef PARTOSERIAL_PARITY_EN
      par_bit      <= 1'b0;
      parity_out   <= 1'b0;
`endif
    end else begin
      if (load) begin
        shreg        <= word;
        order_lsb    <= lsb_first;
        data_out     <= lsb_first ? word[0] : word[WIDTH-1];
        frame_start  <= 1'b1;
        sending_idle <= word_idle;
        if (word_idle && (idle_cnt != {CNT_W{1'b1}}))
          idle_cnt <= idle_cnt + CNT_W'(1);
        if (hold_valid) begin
          hold_valid <= accept;
          if (accept) hold <= data_in;
        end
`ifdef PARTOSERIAL_PARITY_EN
        par_bit <= ^word;
`endif
      end else begin
        data_out    <= ser_bit;
        frame_start <= 1'b0;
        shreg       <= order_lsb ? (shreg >> 1) : (shreg << 1);
        if (accept) begin
          hold       <= data_in;
          hold_valid <= 1'b1;
        end
      end
      bit_cnt <= (bit_cnt == CW'(FL - 1)) ? '0 : bit_cnt + CW'(1);
`ifdef PARTOSERIAL_PARITY_EN
      parity_out <= (bit_cnt == CW'(WIDTH));
`endif
    end
  end

endmodule
